dmem_port: RTL and testbench

Responder for the memory-stage data-access request issued by pipeline control: it accepts the write-enable, access-size and unsigned-load signals plus address and store data, and drives a word-wide synchronous SRAM that has no byte enables. Word stores go straight through; byte and halfword stores need a read-modify-write, and loads need one read cycle. During those extra cycles the block raises `busy` to stall the pipeline. Load data is returned lane-aligned and sign- or zero-extended, ready for writeback.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_port_if.sv | 35 +++
 rtl/load_extend.sv | 31 +++
 rtl/dmem_port.sv | 134 +++++++++++++
 tb/tb_dmem_port.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings and helpers for the data-memory port
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD_WAIT = 2'd1,
        ST_RMW       = 2'd2
    } state_t;

    // Size 3 is handled exactly like a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic result;
        case (size)
            SZ_BYTE: result = 1'b0;
            SZ_HALF: result = offset[0];
            default: result = (offset != 2'd0);
        endcase
        return result;
    endfunction

endpackage

// File: rtl/dmem_port_if.sv
// rtl/dmem_port_if.sv - pipeline request/response and SRAM bus bundle
interface dmem_port_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_un;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              busy;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              misalign;
    logic [ADDR_W-1:0] misalign_addr;
    logic              sram_en;
    logic              sram_we;
    logic [ADDR_W-3:0] sram_addr;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata;

    // Pipeline side plus the SRAM read-data return.
    modport master (
        output req_valid, req_we, req_size, req_un, req_addr, req_wdata, sram_rdata,
        input  busy, rsp_valid, rsp_rdata, misalign, misalign_addr,
        input  sram_en, sram_we, sram_addr, sram_wdata
    );

    // The memory port itself.
    modport slave (
        input  req_valid, req_we, req_size, req_un, req_addr, req_wdata, sram_rdata,
        output busy, rsp_valid, rsp_rdata, misalign, misalign_addr,
        output sram_en, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/load_extend.sv
// rtl/load_extend.sv - lane select and sign/zero extension of a loaded word
module load_extend
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        un,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Pick the addressed little-endian lane, then extend it to 32 bits.
    always_comb begin
        case (offset)
            2'd0:    byte_lane = word[7:0];
            2'd1:    byte_lane = word[15:8];
            2'd2:    byte_lane = word[23:16];
            default: byte_lane = word[31:24];
        endcase
        half_lane = offset[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: result = {{24{byte_lane[7] & ~un}}, byte_lane};
            SZ_HALF: result = {{16{half_lane[15] & ~un}}, half_lane};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/dmem_port.sv
// rtl/dmem_port.sv - M-stage data memory port with sub-word read-modify-write
module dmem_port
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    dmem_port_if.slave  bus
);

    state_t            state;
    logic [1:0]        off_q;
    logic [1:0]        size_q;
    logic              un_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W-3:0] waddr_q;
    logic              misalign_q;
    logic [ADDR_W-1:0] misalign_addr_q;

    logic              req_mis;
    logic              req_is_word;
    logic [31:0]       ext_data;
    logic [31:0]       merged;

    assign req_mis     = is_misaligned(bus.req_size, bus.req_addr[1:0]);
    assign req_is_word = bus.req_size[1];

    load_extend u_load_extend (
        .word   (bus.sram_rdata),
        .offset (off_q),
        .size   (size_q),
        .un     (un_q),
        .result (ext_data)
    );

    // Replace the target lane of the word read in the accept cycle with store data.
    always_comb begin
        merged = bus.sram_rdata;
        if (size_q == SZ_BYTE) begin
            case (off_q)
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (off_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    // State machine: accept in IDLE, one follow-up cycle for loads and sub-word stores.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            off_q           <= 2'd0;
            size_q          <= SZ_BYTE;
            un_q            <= 1'b0;
            wdata_q         <= 32'd0;
            waddr_q         <= '0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        if (req_mis) begin
                            misalign_q <= 1'b1;
                            if (!misalign_q) begin
                                misalign_addr_q <= bus.req_addr;
                            end
                        end else if (!(bus.req_we && req_is_word)) begin
                            off_q   <= bus.req_addr[1:0];
                            size_q  <= bus.req_size;
                            un_q    <= bus.req_un;
                            wdata_q <= bus.req_wdata;
                            waddr_q <= bus.req_addr[ADDR_W-1:2];
                            state   <= bus.req_we ? ST_RMW : ST_LOAD_WAIT;
                        end
                    end
                end
                ST_LOAD_WAIT: state <= ST_IDLE;
                ST_RMW:       state <= ST_IDLE;
                default:      state <= ST_IDLE;
            endcase
        end
    end

    // Strobes and response; reset_n gates the accept path so reset forces everything low.
    always_comb begin
        bus.busy       = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.rsp_rdata  = 32'd0;
        bus.sram_en    = 1'b0;
        bus.sram_we    = 1'b0;
        bus.sram_addr  = '0;
        bus.sram_wdata = 32'd0;
        case (state)
            ST_IDLE: begin
                if (reset_n && bus.req_valid) begin
                    if (req_mis) begin
                        bus.rsp_valid = !bus.req_we;
                    end else if (bus.req_we && req_is_word) begin
                        bus.sram_en    = 1'b1;
                        bus.sram_we    = 1'b1;
                        bus.sram_addr  = bus.req_addr[ADDR_W-1:2];
                        bus.sram_wdata = bus.req_wdata;
                    end else begin
                        bus.sram_en   = 1'b1;
                        bus.sram_addr = bus.req_addr[ADDR_W-1:2];
                        bus.busy      = 1'b1;
                    end
                end
            end
            ST_LOAD_WAIT: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_rdata = ext_data;
            end
            ST_RMW: begin
                bus.sram_en    = 1'b1;
                bus.sram_we    = 1'b1;
                bus.sram_addr  = waddr_q;
                bus.sram_wdata = merged;
            end
            default: ;
        endcase
    end

    assign bus.misalign      = misalign_q;
    assign bus.misalign_addr = misalign_addr_q;

endmodule

// File: tb/tb_dmem_port.sv
// tb/tb_dmem_port.sv - scoreboard bench for dmem_port
module tb_dmem_port;

    localparam int ADDR_W = 32;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    dmem_port_if #(.ADDR_W(ADDR_W)) bus ();

    dmem_port #(.ADDR_W(ADDR_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem    [0:255];
    logic [31:0] shadow [0:255];
    logic [31:0] exp_rsp[$];
    logic [63:0] exp_wr [$];
    logic [31:0] last_rsp = 32'd0;
    logic [31:0] last_wr  = 32'd0;
    int n_rd = 0, n_wr = 0, rd_cyc = 0, wr_cyc = 0, cyc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic ref_mis(input logic [1:0] size, input logic [1:0] off);
        if (size == 2'd1) return off[0];
        if (size >= 2'd2) return off != 2'd0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_ext(input logic [31:0] w, input logic [1:0] off,
                                            input logic [1:0] size, input logic un);
        logic [31:0] s;
        if (size == 2'd0) begin
            s = w >> {off, 3'b000};
            return un ? {24'd0, s[7:0]} : {{24{s[7]}}, s[7:0]};
        end
        if (size == 2'd1) begin
            s = w >> {off[1], 4'b0000};
            return un ? {16'd0, s[15:0]} : {{16{s[15]}}, s[15:0]};
        end
        return w;
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] w, input logic [1:0] off,
                                              input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] mask;
        logic [4:0]  sh;
        sh   = (size == 2'd0) ? {off, 3'b000} : {off[1], 4'b0000};
        mask = ((size == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
        return (w & ~mask) | ((wd << sh) & mask);
    endfunction

    // SRAM model: write on strobe, read data registered for the following cycle.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (bus.sram_en) begin
            if (bus.sram_we) mem[bus.sram_addr[7:0]] <= bus.sram_wdata;
            else             bus.sram_rdata <= mem[bus.sram_addr[7:0]];
        end
    end

    // Output monitor: compares responses and SRAM writes against the scoreboard.
    always @(negedge clock) begin
        if (bus.rsp_valid) begin
            last_rsp = bus.rsp_rdata;
            if (exp_rsp.size() == 0) check("rsp_unexpected", 64'd1, 64'd0);
            else check("rsp_data", {32'd0, bus.rsp_rdata}, {32'd0, exp_rsp.pop_front()});
        end
        if (bus.sram_en && bus.sram_we) begin
            n_wr++;
            wr_cyc  = cyc;
            last_wr = bus.sram_wdata;
            if (exp_wr.size() == 0) check("write_unexpected", 64'd1, 64'd0);
            else check("sram_write", {2'b00, bus.sram_addr, bus.sram_wdata}, exp_wr.pop_front());
        end
        if (bus.sram_en && !bus.sram_we) begin
            n_rd++;
            rd_cyc = cyc;
        end
    end

    logic        exp_mis_flag = 1'b0;
    logic [31:0] exp_mis_addr = 32'd0;

    // Drive one request, push its expectations, hold it until busy drops.
    task automatic run_op(input logic we, input logic [1:0] size, input logic un,
                          input logic [31:0] addr, input logic [31:0] wdata);
        logic [7:0]  idx;
        logic        mis;
        logic [31:0] nw;
        int          exp_busy, nb;
        logic        b, done;
        idx = addr[9:2];
        mis = ref_mis(size, addr[1:0]);
        exp_busy = 0;
        if (!we) begin
            exp_rsp.push_back(mis ? 32'd0 : ref_ext(shadow[idx], addr[1:0], size, un));
            exp_busy = mis ? 0 : 1;
        end else if (!mis) begin
            nw = (size >= 2'd2) ? wdata : ref_merge(shadow[idx], addr[1:0], size, wdata);
            exp_wr.push_back({2'b00, addr[31:2], nw});
            shadow[idx] = nw;
            exp_busy = (size >= 2'd2) ? 0 : 1;
        end
        if (mis && !exp_mis_flag) begin
            exp_mis_flag = 1'b1;
            exp_mis_addr = addr;
        end
        #1;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_size  = size;
        bus.req_un    = un;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        nb   = 0;
        done = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin
            @(negedge clock);
            b = bus.busy;
            @(posedge clock);
            if (b) nb++;
            else   done = 1'b1;
        end
        if (!done) check("op_timeout", 64'd0, 64'd1);
        check("busy_cycles", 64'(nb), 64'(exp_busy));
    endtask

    task automatic idle(input int n);
        #1;
        bus.req_valid = 1'b0;
        repeat (n) @(posedge clock);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] lb_exp [0:3];
    int r0, w0;

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = 32'd0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_size  = 2'd0;
        bus.req_un    = 1'b0;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
        lb_exp[0] = 32'h0000_0001;
        lb_exp[1] = 32'h0000_007F;
        lb_exp[2] = 32'hFFFF_FFFF;
        lb_exp[3] = 32'hFFFF_FF80;

        repeat (3) @(posedge clock);
        #1;
        check("reset_strobes", {59'd0, bus.busy, bus.rsp_valid, bus.sram_en, bus.sram_we, bus.misalign}, 64'd0);
        check("reset_sram_bus", {2'b00, bus.sram_addr, bus.sram_wdata}, 64'd0);
        check("reset_rsp_rdata", {32'd0, bus.rsp_rdata}, 64'd0);
        check("reset_misalign_addr", {32'd0, bus.misalign_addr}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);

        // Word store then word load.
        w0 = n_wr;
        run_op(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF);
        check("sw_one_write", 64'(n_wr - w0), 64'd1);
        run_op(1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
        check("lw_deadbeef", {32'd0, last_rsp}, {32'd0, 32'hDEAD_BEEF});
        idle(2);

        // Byte loads, signed and unsigned.
        run_op(1'b1, 2'd2, 1'b0, 32'h200, 32'h80FF_7F01);
        for (int k = 0; k < 4; k++) begin
            run_op(1'b0, 2'd0, 1'b0, 32'h200 + 32'(k), 32'd0);
            check("lb_lane", {32'd0, last_rsp}, {32'd0, lb_exp[k]});
        end
        run_op(1'b0, 2'd0, 1'b1, 32'h202, 32'd0);
        check("lbu_off2", {32'd0, last_rsp}, 64'h0000_00FF);
        run_op(1'b0, 2'd1, 1'b0, 32'h202, 32'd0);
        run_op(1'b0, 2'd1, 1'b1, 32'h200, 32'd0);
        idle(1);

        // Sub-word read-modify-write.
        run_op(1'b1, 2'd2, 1'b0, 32'h300, 32'h1122_3344);
        run_op(1'b1, 2'd0, 1'b0, 32'h301, 32'h0000_00AA);
        check("sb_merge", {32'd0, last_wr}, 64'h1122_AA44);
        run_op(1'b1, 2'd1, 1'b0, 32'h302, 32'h0000_BEEF);
        check("sh_merge", {32'd0, last_wr}, 64'hBEEF_AA44);
        run_op(1'b0, 2'd2, 1'b0, 32'h300, 32'd0);
        idle(1);

        // Misaligned accesses: no strobes, sticky first address.
        r0 = n_rd;
        w0 = n_wr;
        run_op(1'b0, 2'd2, 1'b0, 32'h102, 32'd0);
        check("mis_lw_rdata", {32'd0, last_rsp}, 64'd0);
        run_op(1'b1, 2'd1, 1'b0, 32'h205, 32'h0000_1234);
        idle(1);
        #2;
        check("mis_no_reads", 64'(n_rd - r0), 64'd0);
        check("mis_no_writes", 64'(n_wr - w0), 64'd0);
        check("misalign_flag", {63'd0, bus.misalign}, {63'd0, exp_mis_flag});
        check("misalign_addr", {32'd0, bus.misalign_addr}, {32'd0, exp_mis_addr});
        check("misalign_addr_first", {32'd0, bus.misalign_addr}, 64'h102);
        idle(1);

        // Back-to-back load then word store.
        r0 = n_rd;
        w0 = n_wr;
        run_op(1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
        run_op(1'b1, 2'd2, 1'b0, 32'h104, 32'hCAFE_F00D);
        check("b2b_reads", 64'(n_rd - r0), 64'd1);
        check("b2b_writes", 64'(n_wr - w0), 64'd1);
        check("b2b_spacing", 64'(wr_cyc - rd_cyc), 64'd2);
        idle(1);

        // Reset asserted during the RMW cycle of a byte store.
        w0 = n_wr;
        #1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = 2'd0;
        bus.req_un    = 1'b0;
        bus.req_addr  = 32'h300;
        bus.req_wdata = 32'h0000_0055;
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_rmw_strobes", {59'd0, bus.busy, bus.rsp_valid, bus.sram_en, bus.sram_we, bus.misalign}, 64'd0);
        check("rst_rmw_bus", {2'b00, bus.sram_addr, bus.sram_wdata}, 64'd0);
        check("rst_rmw_misalign_addr", {32'd0, bus.misalign_addr}, 64'd0);
        exp_mis_flag = 1'b0;
        exp_mis_addr = 32'd0;
        bus.req_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        check("rst_rmw_no_write", 64'(n_wr - w0), 64'd0);
        run_op(1'b0, 2'd2, 1'b0, 32'h300, 32'd0);
        check("rst_rmw_word_kept", {32'd0, last_rsp}, 64'hBEEF_AA44);
        idle(1);

        // Random mix over a preloaded region.
        for (int i = 0; i < 4; i++) run_op(1'b1, 2'd2, 1'b0, 32'h400 + 32'(4 * i), $urandom);
        for (int i = 0; i < 40; i++) begin
            run_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   32'h400 + 32'($urandom_range(0, 15)), $urandom);
        end
        idle(3);

        check("rsp_queue_drained", 64'(exp_rsp.size()), 64'd0);
        check("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
